fb_arbiter: RTL

Owns the single-port framebuffer RAM and shares it between display scanout and game-logic pixel writes. The framebuffer is 200x150 at 6 bpp; each stored pixel is shown as a 4x4 block on the 800x600 screen. Scanout reads are scheduled from the VGA timing core's lookahead outputs (`nextH`, `nextV`, `nextActive`), and the block returns `pixel` to the VGA core. Writes from game logic and from a built-in clear-screen engine use the remaining RAM cycles.

---
 rtl/fb_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer RAM arbiter. Priority is scanout read, then clear engine, then game-logic write.
// The row base y*200 is built from shifts and adds, so it assumes FB_W = 200.
module fb_arbiter #(
  parameter int FB_W   = 200,
  parameter int FB_H   = 150,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       nextH,
  input  logic [9:0]        nextV,
  input  logic              nextActive,
  output logic [5:0]        pixel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [5:0]        wr_data,
  input  logic              clear_start,
  input  logic [5:0]        clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [5:0]        mem_wdata,
  input  logic [5:0]        mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic              rd_slot, rd_d, wr_fire, wr_in_bounds, clr_write, clear_done_next;
  logic [5:0]        pix_hold, clr_color, clr_color_next;
  logic [ADDR_W-1:0] clr_addr, clr_addr_next, addr_q, rd_addr, wr_addr;
  logic              unused_ok;

  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 6) + (ADDR_W'(y) << 3);
  endfunction

  assign unused_ok    = ^nextV[1:0];
  assign rd_slot      = nextActive & (nextH[1:0] == 2'b00);
  assign rd_addr      = row_base(nextV[9:2]) + ADDR_W'(nextH[10:2]);
  assign wr_addr      = row_base(wr_y) + ADDR_W'(wr_x);
  assign wr_in_bounds = (wr_x < 8'(FB_W)) & (wr_y < 8'(FB_H));
  assign wr_ready     = ~rd_slot & (state == IDLE);
  assign wr_fire      = wr_valid & wr_ready;
  assign clr_write    = (state == CLEAR) & ~rd_slot;
  assign clear_busy   = (state == CLEAR);
  assign pixel        = rd_d ? mem_rdata : pix_hold;

  // RAM command mux; with no owner the address parks on its previous value.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rd_slot) begin
      mem_addr = rd_addr;
    end else if (state == CLEAR) begin
      mem_addr  = clr_addr;
      mem_we    = 1'b1;
      mem_wdata = clr_color;
    end else if (wr_fire) begin
      mem_addr  = wr_addr;
      mem_we    = wr_in_bounds;
      mem_wdata = wr_data;
    end
  end

  always_comb begin
    state_next      = state;
    clr_addr_next   = clr_addr;
    clr_color_next  = clr_color;
    clear_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_next     = CLEAR;
          clr_addr_next  = '0;
          clr_color_next = clear_color;
        end
      end
      CLEAR: begin
        if (clr_write) begin
          if (clr_addr == LAST_ADDR) begin
            state_next      = IDLE;
            clr_addr_next   = '0;
            clear_done_next = 1'b1;
          end else begin
            clr_addr_next = clr_addr + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_addr   <= '0;
      clr_color  <= '0;
      clear_done <= 1'b0;
      rd_d       <= 1'b0;
      pix_hold   <= '0;
      addr_q     <= '0;
    end else begin
      state      <= state_next;
      clr_addr   <= clr_addr_next;
      clr_color  <= clr_color_next;
      clear_done <= clear_done_next;
      rd_d       <= rd_slot;
      addr_q     <= mem_addr;
      if (rd_d) pix_hold <= mem_rdata;
    end
  end

endmodule
